// File: rtl/hazard_scoreboard.sv
// Hazard unit with per-register countdown scoreboards for int and float files.
// Drives stall and flush controls for the IF/ID and ID/EX pipeline registers.
module hazard_scoreboard #(
    parameter int NREG  = 32,
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             validD,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs3D,
    input  logic             src1_is_floatD,
    input  logic             src2_is_floatD,
    input  logic             src3_is_floatD,
    input  logic             use1D,
    input  logic             use2D,
    input  logic             use3D,
    input  logic [4:0]       RdD,
    input  logic             RegWriteD,
    input  logic             RegFWriteD,
    input  logic [LAT_W-1:0] latD,
    input  logic             MemReadE,
    input  logic             RegWriteE,
    input  logic             RegFWriteE,
    input  logic [4:0]       RdE,
    input  logic             PCSrcE,
    input  logic             mem_busy,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             StallE,
    output logic             sb_busy
);

    logic [LAT_W-1:0] int_cnt [NREG];
    logic [LAT_W-1:0] fp_cnt  [NREG];

    logic [4:0] rs [3];
    logic [2:0] is_float;
    logic [2:0] used;
    logic [2:0] pend;
    logic [2:0] lu_hit;
    logic       waw;
    logic       hz;
    logic       issue;

    assign rs[0]    = Rs1D;
    assign rs[1]    = Rs2D;
    assign rs[2]    = Rs3D;
    assign is_float = {src3_is_floatD, src2_is_floatD, src1_is_floatD};
    assign used     = {use3D, use2D, use1D};

    // Per-source scoreboard pending and load-use match against E.
    always_comb begin
        pend   = '0;
        lu_hit = '0;
        for (int k = 0; k < 3; k++) begin
            if (used[k] && validD) begin
                if (is_float[k]) begin
                    pend[k]   = fp_cnt[rs[k]] != '0;
                    lu_hit[k] = MemReadE && RegFWriteE && (RdE == rs[k]);
                end else begin
                    pend[k]   = (rs[k] != 5'd0) && (int_cnt[rs[k]] != '0);
                    lu_hit[k] = MemReadE && RegWriteE && (RdE != 5'd0)
                                && (RdE == rs[k]);
                end
            end
        end
    end

    assign waw = validD &&
                 ((RegWriteD && (RdD != 5'd0) && (int_cnt[RdD] != '0)) ||
                  (RegFWriteD && (fp_cnt[RdD] != '0)));

    assign hz    = (|pend) || waw || (|lu_hit);
    assign issue = validD && !mem_busy && !PCSrcE && !hz;

    // Prioritised control: memory freeze, then redirect, then hazard.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        StallE = 1'b0;
        if (mem_busy) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (hz) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // Busy when any counter is still running.
    always_comb begin
        sb_busy = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            sb_busy = sb_busy || (int_cnt[i] != '0) || (fp_cnt[i] != '0);
        end
    end

    // Countdown each counter; an issuing long-latency writer reloads its slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                int_cnt[i] <= '0;
                fp_cnt[i]  <= '0;
            end
        end else if (!mem_busy) begin
            for (int i = 0; i < NREG; i++) begin
                if (i == 0) begin
                    int_cnt[i] <= '0;
                end else if (issue && (latD != '0) && RegWriteD
                             && (RdD == 5'(i))) begin
                    int_cnt[i] <= latD;
                end else if (int_cnt[i] != '0) begin
                    int_cnt[i] <= int_cnt[i] - LAT_W'(1);
                end
                if (issue && (latD != '0) && RegFWriteD
                    && (RdD == 5'(i))) begin
                    fp_cnt[i] <= latD;
                end else if (fp_cnt[i] != '0) begin
                    fp_cnt[i] <= fp_cnt[i] - LAT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic
// checked against a register-indexed latency model.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       validD;
    logic [4:0] Rs1D, Rs2D, Rs3D;
    logic       src1_is_floatD, src2_is_floatD, src3_is_floatD;
    logic       use1D, use2D, use3D;
    logic [4:0] RdD;
    logic       RegWriteD, RegFWriteD;
    logic [3:0] latD;
    logic       MemReadE, RegWriteE, RegFWriteE;
    logic [4:0] RdE;
    logic       PCSrcE, mem_busy;
    logic       StallF, StallD, FlushD, FlushE, StallE, sb_busy;

    int total = 0;
    int bad = 0;

    int im [32];
    int fm [32];

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .validD(validD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs3D(Rs3D),
        .src1_is_floatD(src1_is_floatD), .src2_is_floatD(src2_is_floatD),
        .src3_is_floatD(src3_is_floatD),
        .use1D(use1D), .use2D(use2D), .use3D(use3D),
        .RdD(RdD), .RegWriteD(RegWriteD), .RegFWriteD(RegFWriteD),
        .latD(latD), .MemReadE(MemReadE), .RegWriteE(RegWriteE),
        .RegFWriteE(RegFWriteE), .RdE(RdE), .PCSrcE(PCSrcE),
        .mem_busy(mem_busy), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FlushE(FlushE), .StallE(StallE),
        .sb_busy(sb_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {StallF, StallD, FlushD, FlushE, StallE, sb_busy};
    endfunction

    // A source is blocked if its register still has cycles to run,
    // or if the load in E is about to write it.
    function automatic logic src_blocked(logic u, logic [4:0] r, logic f);
        logic busy_reg;
        logic ld;
        if (!u) return 1'b0;
        busy_reg = f ? (fm[r] > 0) : (r != 0 && im[r] > 0);
        ld = MemReadE && (f ? (RegFWriteE && RdE == r)
                            : (RegWriteE && RdE != 0 && RdE == r));
        return busy_reg || ld;
    endfunction

    function automatic logic model_hz();
        logic h;
        if (!validD) return 1'b0;
        h = src_blocked(use1D, Rs1D, src1_is_floatD)
          || src_blocked(use2D, Rs2D, src2_is_floatD)
          || src_blocked(use3D, Rs3D, src3_is_floatD);
        if (RegWriteD && RdD != 0 && im[RdD] > 0) h = 1'b1;
        if (RegFWriteD && fm[RdD] > 0) h = 1'b1;
        return h;
    endfunction

    function automatic logic [5:0] model_out();
        logic busy = 1'b0;
        for (int i = 0; i < 32; i++)
            if (im[i] > 0 || fm[i] > 0) busy = 1'b1;
        if (mem_busy) return {5'b11001, busy};
        if (PCSrcE) return {5'b00110, busy};
        if (model_hz()) return {5'b11010, busy};
        return {5'b00000, busy};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin
            im[i] = 0;
            fm[i] = 0;
        end
    endtask

    task automatic idle();
        validD = 0; Rs1D = 0; Rs2D = 0; Rs3D = 0;
        src1_is_floatD = 0; src2_is_floatD = 0; src3_is_floatD = 0;
        use1D = 0; use2D = 0; use3D = 0;
        RdD = 0; RegWriteD = 0; RegFWriteD = 0; latD = 0;
        MemReadE = 0; RegWriteE = 0; RegFWriteE = 0; RdE = 0;
        PCSrcE = 0; mem_busy = 0;
    endtask

    // One clock: model advances with the same inputs the DUT sees.
    task automatic tick();
        logic iss;
        iss = validD && !mem_busy && !PCSrcE && !model_hz();
        @(posedge clk);
        if (!mem_busy) begin
            for (int i = 0; i < 32; i++) begin
                if (im[i] > 0) im[i]--;
                if (fm[i] > 0) fm[i]--;
            end
            if (iss && latD != 0) begin
                if (RegWriteD && RdD != 0) im[RdD] = latD;
                if (RegFWriteD) fm[RdD] = latD;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0;
        clear_model();
        #2;
        reset = 1;
        #1;
    endtask

    task automatic issue_wr(logic f, logic [4:0] rd, logic [3:0] lat);
        idle();
        validD = 1; RdD = rd; latD = lat;
        RegWriteD = !f; RegFWriteD = f;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        do_reset();
        #1;
        total++;
        if (outs() !== 6'b0) begin
            bad++;
            $display("FAIL reset_outs got=%b want=%b", outs(), 6'b0);
        end
    endtask

    task automatic test_fdiv_latency();
        issue_wr(1, 5'd5, 4'd5);
        validD = 1; Rs1D = 5; src1_is_floatD = 1; use1D = 1;
        #1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (!(StallD === 1 && FlushE === 1 && sb_busy === 1)) begin
                bad++;
                $display("FAIL fdiv_stall cyc=%0d got=%b want=11x1x1",
                         i, outs());
            end
            tick();
        end
        total++;
        if (outs() !== 6'b0) begin
            bad++;
            $display("FAIL fdiv_release got=%b want=%b", outs(), 6'b0);
        end
        idle();
    endtask

    task automatic test_load_use();
        idle();
        MemReadE = 1; RegWriteE = 1; RdE = 7;
        validD = 1; use1D = 1; Rs1D = 7;
        #1;
        total++;
        if (outs() !== 6'b110100) begin
            bad++;
            $display("FAIL load_use got=%b want=%b", outs(), 6'b110100);
        end
        Rs1D = 0;
        #1;
        total++;
        if (outs() !== 6'b0) begin
            bad++;
            $display("FAIL load_use_x0 got=%b want=%b", outs(), 6'b0);
        end
        Rs1D = 7;
        tick();
        MemReadE = 0; RegWriteE = 0; RdE = 0;
        #1;
        total++;
        if (outs() !== 6'b0) begin
            bad++;
            $display("FAIL load_use_after got=%b want=%b", outs(), 6'b0);
        end
        idle();
    endtask

    task automatic test_file_separation();
        issue_wr(0, 5'd3, 4'd3);
        validD = 1; use1D = 1; Rs1D = 3; src1_is_floatD = 1;
        #1;
        total++;
        if (StallD !== 0 || sb_busy !== 1) begin
            bad++;
            $display("FAIL float_vs_int got=%b want=000001", outs());
        end
        src1_is_floatD = 0;
        #1;
        total++;
        if (outs() !== 6'b110101) begin
            bad++;
            $display("FAIL int_pending got=%b want=%b", outs(), 6'b110101);
        end
        idle();
        repeat (3) tick();
    endtask

    task automatic test_redirect();
        issue_wr(0, 5'd4, 4'd4);
        validD = 1; use1D = 1; Rs1D = 4;
        RegWriteD = 1; RdD = 10; latD = 5; PCSrcE = 1;
        #1;
        total++;
        if (outs() !== 6'b001101) begin
            bad++;
            $display("FAIL redirect got=%b want=%b", outs(), 6'b001101);
        end
        tick();
        idle();
        validD = 1; use1D = 1; Rs1D = 10;
        #1;
        total++;
        if (StallD !== 0) begin
            bad++;
            $display("FAIL squash_no_set stalld=%b want=0", StallD);
        end
        Rs1D = 4;
        #1;
        total++;
        if (StallD !== 1) begin
            bad++;
            $display("FAIL redirect_keep_cnt stalld=%b want=1", StallD);
        end
        idle();
        repeat (4) tick();
    endtask

    task automatic test_mem_busy();
        issue_wr(1, 5'd2, 4'd2);
        validD = 1; use1D = 1; Rs1D = 2; src1_is_floatD = 1;
        mem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (outs() !== 6'b110011) begin
                bad++;
                $display("FAIL mem_busy cyc=%0d got=%b want=%b",
                         i, outs(), 6'b110011);
            end
            tick();
        end
        mem_busy = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (outs() !== 6'b110101) begin
                bad++;
                $display("FAIL mem_release cyc=%0d got=%b want=%b",
                         i, outs(), 6'b110101);
            end
            tick();
        end
        total++;
        if (outs() !== 6'b0) begin
            bad++;
            $display("FAIL mem_drain got=%b want=%b", outs(), 6'b0);
        end
        idle();
    endtask

    task automatic test_waw_reset();
        issue_wr(0, 5'd9, 4'd6);
        repeat (2) tick();
        validD = 1; RegWriteD = 1; RdD = 9; latD = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (outs() !== 6'b110101) begin
                bad++;
                $display("FAIL waw cyc=%0d got=%b want=%b",
                         i, outs(), 6'b110101);
            end
            tick();
        end
        @(negedge clk);
        reset = 0;
        clear_model();
        #1;
        total++;
        if (outs() !== 6'b0) begin
            bad++;
            $display("FAIL reset_mid got=%b want=%b", outs(), 6'b0);
        end
        #1;
        reset = 1;
        #1;
        idle();
    endtask

    task automatic test_random();
        logic [5:0] want;
        for (int n = 0; n < 600; n++) begin
            idle();
            validD = ($urandom_range(0, 4) != 0);
            Rs1D = 5'($urandom_range(0, 3));
            Rs2D = 5'($urandom_range(0, 3));
            Rs3D = 5'($urandom_range(0, 3));
            src1_is_floatD = 1'($urandom);
            src2_is_floatD = 1'($urandom);
            src3_is_floatD = 1'($urandom);
            use1D = 1'($urandom);
            use2D = 1'($urandom);
            use3D = ($urandom_range(0, 3) == 0);
            RdD = 5'($urandom_range(0, 3));
            RegWriteD = 1'($urandom);
            RegFWriteD = ($urandom_range(0, 3) == 0);
            latD = ($urandom_range(0, 1) == 0) ? 4'd0
                                               : 4'($urandom_range(1, 15));
            MemReadE = ($urandom_range(0, 2) == 0);
            RegWriteE = 1'($urandom);
            RegFWriteE = 1'($urandom);
            RdE = 5'($urandom_range(0, 3));
            PCSrcE = ($urandom_range(0, 9) == 0);
            mem_busy = ($urandom_range(0, 9) == 0);
            #1;
            want = model_out();
            total++;
            if (outs() !== want) begin
                bad++;
                $display("FAIL random n=%0d got=%b want=%b", n, outs(), want);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        clear_model();
        test_reset();
        test_fdiv_latency();
        test_load_use();
        test_file_separation();
        test_redirect();
        test_mem_busy();
        test_waw_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Control-side counterpart of the ID/EX pipeline register: generates the Stall/flush controls the decode-to-execute boundary consumes (StallF, StallD, FlushD, FlushE).
- Tracks in-flight multi-cycle results (DIV, FDIV, FSQRT, FMA) in per-register countdown scoreboards for the integer and float files.
- Detects load-use hazards against the E stage, applies redirects from branch/jump resolution, and freezes the whole front end while the AXI memory side is busy.

Parameters:
- NREG, 32, registers per file.
- LAT_W, 4, countdown counter width; max tracked latency is 2^LAT_W-1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- validD  in  1  D stage holds a real instruction
- Rs1D, Rs2D, Rs3D  in  5 each  D-stage source indices
- src1_is_floatD, src2_is_floatD, src3_is_floatD  in  1 each  source reads the float file
- use1D, use2D, use3D  in  1 each  source is actually read
- RdD  in  5  D-stage destination
- RegWriteD, RegFWriteD  in  1 each  D writes the int / float file
- latD  in  LAT_W  result latency of the D instruction; 0 = single-cycle or forwardable
- MemReadE, RegWriteE, RegFWriteE  in  1 each  E-stage controls
- RdE  in  5  E-stage destination
- PCSrcE  in  1  taken branch/jump resolved in E
- mem_busy  in  1  AXI load/store outstanding; back end frozen
- StallF, StallD  out  1  hold IF PC and the IF/ID register
- FlushD  out  1  clear IF/ID
- FlushE  out  1  bubble into ID/EX (drives its flush input)
- StallE  out  1  hold ID/EX (drives its Stall input)
- sb_busy  out  1  any scoreboard counter nonzero

Behaviour:
- State: int_cnt[NREG] and fp_cnt[NREG], each LAT_W bits. Reset clears all to 0. int_cnt[0] is hard-wired to 0.
- All outputs are combinational from state and inputs. After reset, with all inputs at 0, every output is 0.
- Per-source pending flag: pend_k = use_kD & validD & (src_k_is_floatD ? fp_cnt[Rs_kD]!=0 : (Rs_kD!=0 & int_cnt[Rs_kD]!=0)).
- WAW flag: waw = validD & ((RegWriteD & RdD!=0 & int_cnt[RdD]!=0) | (RegFWriteD & fp_cnt[RdD]!=0)).
- Load-use flag: lu = MemReadE & validD & some used source k matches RdE in the same file. Integer match requires RegWriteE and RdE!=0; float match requires RegFWriteE.
- hz = any pend_k | waw | lu.
- Priority, highest first:
  1. mem_busy: StallF=StallD=StallE=1; FlushD=FlushE=0; counters frozen; no issue.
  2. PCSrcE: FlushD=FlushE=1; StallF=StallD=StallE=0; no issue. A pending hazard is discarded because the D instruction is squashed.
  3. hz: StallF=StallD=1; FlushE=1; StallE=0.
  4. Otherwise: all 0, and the D instruction issues.
- Issue = validD & !mem_busy & !PCSrcE & !hz.
- Clock edge, when not frozen: every nonzero counter decrements by 1. Then, if issue & latD!=0, the destination counter loads latD (int_cnt[RdD] if RegWriteD & RdD!=0; fp_cnt[RdD] if RegFWriteD).
- Set and decrement on the same register at the same edge: set wins, counter = latD.
- Counters saturate at 0 and never wrap.
- A counter of N means a reader in D stalls for exactly N cycles, then proceeds via forwarding.
- sb_busy = OR of all counters != 0.
- Reset asserted mid-operation clears all counters immediately; outputs drop to 0 unless inputs demand otherwise.
- Issue with latD!=0 and both RegWriteD and RegFWriteD low: counters unchanged.

Test Plan:
- Reset, then issue FDIV with RdD=f5, RegFWriteD=1, latD=5. Next instruction reads f5 (src1_is_floatD=1) -> StallD=1 and FlushE=1 for exactly 5 cycles, 0 on the 6th; sb_busy falls on the same edge.
- Load to x7 in E (MemReadE=1, RegWriteE=1, RdE=7), D reads x7 -> one cycle of StallF=StallD=FlushE=1. D reads x0 instead -> no stall.
- Int counter x3=3, D reads f3 (float) -> no stall. D reads x3 -> stall.
- Stall active and PCSrcE=1 in the same cycle -> FlushD=FlushE=1, StallD=0, and no counter is set for the squashed instruction.
- mem_busy=1 for 4 cycles with fp_cnt[f2]=2 -> StallF/D/E=1, counter holds at 2. After release it reaches 0 two cycles later.
- DIV to x9 with latD=6, then after 2 cycles a D instruction writes x9 with latD=0 -> WAW stall for 4 cycles. Assert reset mid-stall -> stall drops at once and all counters are 0.
